matrix_alu_seq: RTL and testbench

- Sequential, parametrised successor to the combinational matrix ALU. Element width and maximum matrix dimension are parameters.
- Processes one element per cycle for element-wise operations, and one multiply-accumulate per cycle for matrix multiplication.
- Sits between the coprocessor instruction decoder and the matrix register file.
- Uses a start/busy/done handshake with latched operands, so the input buses may change while the block is busy.

---
 rtl/matrix_alu_seq.sv | 144 ++++++++++++++
 tb/tb_matrix_alu_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_alu_seq.sv
// Sequential matrix ALU: latches operands on start, then walks one element
// (or one multiply-accumulate term) per cycle before a single-cycle FINISH.
module matrix_alu_seq #(
   parameter int DATA_W = 8,
   parameter int MAX_N  = 5
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            start,
   input  logic [2:0]                      opcode,
   input  logic [2:0]                      matrix_size,
   input  logic [MAX_N*MAX_N*DATA_W-1:0]   A_flat,
   input  logic [MAX_N*MAX_N*DATA_W-1:0]   B_flat,
   input  logic [DATA_W-1:0]               scalar,
   output logic [MAX_N*MAX_N*DATA_W-1:0]   C_flat,
   output logic                            busy,
   output logic                            done,
   output logic                            overflow_flag,
   output logic                            error,
   output logic [1:0]                      state_dbg
);

   localparam int FW    = MAX_N * MAX_N * DATA_W;
   localparam int ACC_W = 2 * DATA_W + $clog2(MAX_N);

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_NEG = 3'b100;
   localparam logic [2:0] OP_TRN = 3'b101;
   localparam logic [2:0] OP_SCL = 3'b110;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

   state_t                    state, state_nxt;
   logic [2:0]                op_q, n_q, n_m1;
   logic [FW-1:0]             a_q, b_q, res, res_nxt;
   logic [DATA_W-1:0]         s_q;
   logic [2:0]                row, col, k;
   logic signed [ACC_W-1:0]   acc, acc_nxt, full;
   logic                      ovf_q, elem_ovf, wr_en, last, invalid;
   logic signed [DATA_W-1:0]  a_rc, a_cr, b_rc, a_rk, b_kc;

   function automatic int idx(input logic [2:0] r, input logic [2:0] c);
      return int'(r) * MAX_N + int'(c);
   endfunction

   function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
      return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
   endfunction

   assign invalid   = (opcode == 3'b000) || (opcode == 3'b111) ||
                      (matrix_size == 3'd0) || (int'(matrix_size) > MAX_N);
   assign n_m1      = n_q - 3'd1;
   assign a_rc      = a_q[idx(row, col)*DATA_W +: DATA_W];
   assign a_cr      = a_q[idx(col, row)*DATA_W +: DATA_W];
   assign b_rc      = b_q[idx(row, col)*DATA_W +: DATA_W];
   assign a_rk      = a_q[idx(row, k)*DATA_W +: DATA_W];
   assign b_kc      = b_q[idx(k, col)*DATA_W +: DATA_W];
   assign busy      = (state == RUN);
   assign done      = (state == FINISH);
   assign state_dbg = state;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = invalid ? FINISH : RUN;
         RUN:     if (last)  state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Results are formed at full accumulator width so overflow can be seen
   // before truncation; multiply only writes on its last k term.
   always_comb begin
      acc_nxt = acc;
      full    = '0;
      wr_en   = 1'b1;
      case (op_q)
         OP_ADD: full = sext(a_rc) + sext(b_rc);
         OP_SUB: full = sext(a_rc) - sext(b_rc);
         OP_MUL: begin
            acc_nxt = acc + sext(a_rk) * sext(b_kc);
            full    = acc_nxt;
            wr_en   = (k == n_m1);
         end
         OP_NEG: full = -sext(a_rc);
         OP_TRN: full = sext(a_cr);
         OP_SCL: full = sext(a_rc) * sext(s_q);
         default: full = '0;
      endcase
      elem_ovf = wr_en && (full[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){full[DATA_W-1]}});
      res_nxt  = res;
      if (wr_en) res_nxt[idx(row, col)*DATA_W +: DATA_W] = full[DATA_W-1:0];
      last     = wr_en && (row == n_m1) && (col == n_m1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         op_q <= '0; n_q <= '0; a_q <= '0; b_q <= '0; s_q <= '0;
         row <= '0; col <= '0; k <= '0; acc <= '0; res <= '0; ovf_q <= 1'b0;
         C_flat <= '0; overflow_flag <= 1'b0; error <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op_q <= opcode; n_q <= matrix_size;
               a_q <= A_flat; b_q <= B_flat; s_q <= scalar;
               row <= '0; col <= '0; k <= '0; acc <= '0; res <= '0; ovf_q <= 1'b0;
               overflow_flag <= 1'b0;
               error         <= invalid;
               if (invalid) C_flat <= '0;
            end
            RUN: begin
               res   <= res_nxt;
               ovf_q <= ovf_q | elem_ovf;
               acc   <= wr_en ? '0 : acc_nxt;
               if (wr_en) begin
                  k <= '0;
                  if (col == n_m1) begin
                     col <= '0;
                     row <= row + 3'd1;
                  end else begin
                     col <= col + 3'd1;
                  end
               end else begin
                  k <= k + 3'd1;
               end
               if (last) begin
                  C_flat        <= res_nxt;
                  overflow_flag <= ovf_q | elem_ovf;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Bench for matrix_alu_seq: scenario tasks drive operations, a reference
// model fills expectation queues, and results are popped when done pulses.
module tb_matrix_alu_seq;

   localparam int DW = 8;
   localparam int MN = 5;
   localparam int FW = MN * MN * DW;
   localparam int LIM_HI = (1 << (DW - 1)) - 1;
   localparam int LIM_LO = -(1 << (DW - 1));

   logic          clock, reset, start;
   logic [2:0]    opcode, matrix_size;
   logic [FW-1:0] a_flat, b_flat, c_flat;
   logic [DW-1:0] scalar;
   logic          busy, done, ovf, err;
   logic [1:0]    state_dbg;

   logic [FW-1:0] exp_q[$];
   logic          exp_o_q[$];
   logic          exp_e_q[$];
   int            exp_l_q[$];
   int            errors = 0;
   int            checks = 0;

   matrix_alu_seq #(.DATA_W(DW), .MAX_N(MN)) dut (
      .clock(clock), .reset(reset), .start(start), .opcode(opcode),
      .matrix_size(matrix_size), .A_flat(a_flat), .B_flat(b_flat),
      .scalar(scalar), .C_flat(c_flat), .busy(busy), .done(done),
      .overflow_flag(ovf), .error(err), .state_dbg(state_dbg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int ga(input logic [FW-1:0] m, input int r, input int c);
      logic signed [DW-1:0] v;
      v = m[(r*MN+c)*DW +: DW];
      return int'(v);
   endfunction

   function automatic logic [FW-1:0] put(input logic [FW-1:0] m, input int r, input int c, input int v);
      logic [FW-1:0] t;
      t = m;
      t[(r*MN+c)*DW +: DW] = v[DW-1:0];
      return t;
   endfunction

   task automatic model(input logic [2:0] op, input int n, input logic [FW-1:0] a, input logic [FW-1:0] b,
                        input logic [DW-1:0] s, output logic [FW-1:0] c, output logic o, output logic e);
      int full;
      c = '0; o = 1'b0;
      e = (op == 3'd0) || (op == 3'd7) || (n < 1) || (n > MN);
      if (!e) begin
         for (int r = 0; r < n; r++) begin
            for (int cc = 0; cc < n; cc++) begin
               full = 0;
               case (op)
                  3'd1: full = ga(a, r, cc) + ga(b, r, cc);
                  3'd2: full = ga(a, r, cc) - ga(b, r, cc);
                  3'd3: for (int kk = 0; kk < n; kk++) full += ga(a, r, kk) * ga(b, kk, cc);
                  3'd4: full = -ga(a, r, cc);
                  3'd5: full = ga(a, cc, r);
                  default: full = ga(a, r, cc) * int'($signed(s));
               endcase
               if (full > LIM_HI || full < LIM_LO) o = 1'b1;
               c = put(c, r, cc, full);
            end
         end
      end
   endtask

   task automatic expect_push(input logic [2:0] op, input int n, input logic [FW-1:0] a,
                              input logic [FW-1:0] b, input logic [DW-1:0] s);
      logic [FW-1:0] c;
      logic o, e;
      model(op, n, a, b, s, c, o, e);
      exp_q.push_back(c);
      exp_o_q.push_back(o);
      exp_e_q.push_back(e);
      exp_l_q.push_back(e ? 1 : (op == 3'd3) ? 1 + n*n*n : 1 + n*n);
   endtask

   task automatic pop_exp(output logic [FW-1:0] c, output logic o, output logic e, output int l);
      c = exp_q.pop_front();
      o = exp_o_q.pop_front();
      e = exp_e_q.pop_front();
      l = exp_l_q.pop_front();
   endtask

   // Drives one start pulse, then scrambles the input buses.
   task automatic issue(input logic [2:0] op, input int n, input logic [FW-1:0] a,
                        input logic [FW-1:0] b, input logic [DW-1:0] s);
      @(negedge clock);
      opcode = op; matrix_size = n[2:0]; a_flat = a; b_flat = b; scalar = s; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0; a_flat = ~a; b_flat = ~b; scalar = ~s;
      opcode = 3'($urandom_range(0, 7)); matrix_size = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_done(output int cyc, output logic busy_first);
      cyc = 0;
      busy_first = 1'b0;
      do begin
         @(negedge clock);
         cyc++;
         if (cyc == 1) busy_first = busy;
      end while (!done && cyc < 2000);
   endtask

   function automatic logic [FW-1:0] rand_mat();
      logic [FW-1:0] m;
      m = '0;
      for (int i = 0; i < MN*MN; i++) m = put(m, i / MN, i % MN, int'($urandom_range(0, 255)));
      return m;
   endfunction

   task automatic test_reset();
      reset = 1'b1; start = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++; if (c_flat !== '0) begin errors++; $display("FAIL reset_c: got %h want 0", c_flat); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (ovf !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b err=%b want 0 0", ovf, err); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
      reset = 1'b0;
   endtask

   task automatic test_sum();
      logic [FW-1:0] a, b, ce;
      logic oe, ee, bf;
      int le, lat;
      a = put(put(put(put('0, 0, 0, 1), 0, 1, 2), 1, 0, 3), 1, 1, 4);
      b = put(put(put(put('0, 0, 0, 10), 0, 1, 20), 1, 0, 30), 1, 1, 40);
      expect_push(3'd1, 2, a, b, '0);
      issue(3'd1, 2, a, b, '0);
      wait_done(lat, bf);
      pop_exp(ce, oe, ee, le);
      checks++; if (lat !== 5) begin errors++; $display("FAIL sum_latency: got %0d want 5", lat); end
      checks++; if (bf !== 1'b1) begin errors++; $display("FAIL sum_busy: got %b want 1", bf); end
      checks++; if (c_flat !== ce) begin errors++; $display("FAIL sum_c: got %h want %h", c_flat, ce); end
      checks++; if (ga(c_flat, 1, 1) !== 44 || ga(c_flat, 0, 0) !== 11) begin errors++; $display("FAIL sum_elem: got %0d %0d want 11 44", ga(c_flat, 0, 0), ga(c_flat, 1, 1)); end
      checks++; if (ovf !== oe || err !== ee) begin errors++; $display("FAIL sum_flags: got ovf=%b err=%b want %b %b", ovf, err, oe, ee); end
      @(negedge clock);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sum_pulse: got done=%b busy=%b want 0 0", done, busy); end
      checks++; if (c_flat !== ce) begin errors++; $display("FAIL sum_hold: got %h want %h", c_flat, ce); end
   endtask

   task automatic test_multiply();
      logic [FW-1:0] id, b, ce;
      logic oe, ee, bf;
      int le, lat;
      id = put(put(put('0, 0, 0, 1), 1, 1, 1), 2, 2, 1);
      b = '0;
      for (int i = 0; i < 9; i++) b = put(b, i / 3, i % 3, i + 1);
      expect_push(3'd3, 3, id, b, '0);
      issue(3'd3, 3, id, b, '0);
      wait_done(lat, bf);
      pop_exp(ce, oe, ee, le);
      checks++; if (lat !== 28) begin errors++; $display("FAIL mul_id_latency: got %0d want 28", lat); end
      checks++; if (c_flat !== b) begin errors++; $display("FAIL mul_id_c: got %h want %h", c_flat, b); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mul_id_ovf: got %b want 0", ovf); end
      expect_push(3'd3, 3, b, b, '0);
      issue(3'd3, 3, b, b, '0);
      wait_done(lat, bf);
      pop_exp(ce, oe, ee, le);
      checks++; if (lat !== le) begin errors++; $display("FAIL mul_sq_latency: got %0d want %0d", lat, le); end
      checks++; if (c_flat !== ce) begin errors++; $display("FAIL mul_sq_c: got %h want %h", c_flat, ce); end
      checks++; if (ga(c_flat, 0, 0) !== 30 || ga(c_flat, 2, 2) !== -106) begin errors++; $display("FAIL mul_sq_elem: got %0d %0d want 30 -106", ga(c_flat, 0, 0), ga(c_flat, 2, 2)); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL mul_sq_ovf: got %b want 1", ovf); end
   endtask

   task automatic test_overflow();
      int op_t[3] = '{1, 4, 6};
      int a_t[3]  = '{100, -128, -3};
      int b_t[3]  = '{100, 0, 0};
      int s_t[3]  = '{0, 0, 5};
      int c_t[3]  = '{-56, -128, -15};
      logic o_t[3] = '{1'b1, 1'b1, 1'b0};
      logic [FW-1:0] a, b, ce;
      logic [DW-1:0] s;
      logic oe, ee, bf;
      int le, lat;
      for (int i = 0; i < 3; i++) begin
         a = put('0, 0, 0, a_t[i]);
         b = put('0, 0, 0, b_t[i]);
         s = s_t[i][DW-1:0];
         expect_push(op_t[i][2:0], 1, a, b, s);
         issue(op_t[i][2:0], 1, a, b, s);
         wait_done(lat, bf);
         pop_exp(ce, oe, ee, le);
         checks++; if (lat !== 2) begin errors++; $display("FAIL ovf%0d_latency: got %0d want 2", i, lat); end
         checks++; if (c_flat !== ce || ga(c_flat, 0, 0) !== c_t[i]) begin errors++; $display("FAIL ovf%0d_c: got %0d want %0d", i, ga(c_flat, 0, 0), c_t[i]); end
         checks++; if (ovf !== o_t[i] || err !== 1'b0) begin errors++; $display("FAIL ovf%0d_flags: got ovf=%b err=%b want %b 0", i, ovf, err, o_t[i]); end
      end
   endtask

   task automatic test_transpose();
      logic [FW-1:0] a, ce;
      logic oe, ee, bf;
      int le, lat;
      a = '0;
      for (int i = 0; i < MN*MN; i++) a = put(a, i / MN, i % MN, i);
      expect_push(3'd5, 5, a, '0, '0);
      issue(3'd5, 5, a, '0, '0);
      wait_done(lat, bf);
      pop_exp(ce, oe, ee, le);
      checks++; if (lat !== 26) begin errors++; $display("FAIL trn_latency: got %0d want 26", lat); end
      checks++; if (c_flat !== ce) begin errors++; $display("FAIL trn_c: got %h want %h", c_flat, ce); end
      checks++; if (ga(c_flat, 1, 3) !== 16 || ga(c_flat, 4, 0) !== 4) begin errors++; $display("FAIL trn_elem: got %0d %0d want 16 4", ga(c_flat, 1, 3), ga(c_flat, 4, 0)); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL trn_ovf: got %b want 0", ovf); end
   endtask

   task automatic test_error();
      int op_t[4] = '{7, 3, 0, 1};
      int n_t[4]  = '{3, 6, 2, 0};
      logic [FW-1:0] ce;
      logic oe, ee, bf;
      int le, lat;
      for (int i = 0; i < 4; i++) begin
         expect_push(op_t[i][2:0], n_t[i], rand_mat(), rand_mat(), 8'd3);
         issue(op_t[i][2:0], n_t[i], rand_mat(), rand_mat(), 8'd3);
         wait_done(lat, bf);
         pop_exp(ce, oe, ee, le);
         checks++; if (lat !== 1 || bf !== 1'b0) begin errors++; $display("FAIL err%0d_timing: got lat=%0d busy=%b want 1 0", i, lat, bf); end
         checks++; if (err !== 1'b1 || ee !== 1'b1) begin errors++; $display("FAIL err%0d_flag: got %b want 1", i, err); end
         checks++; if (c_flat !== '0 || ovf !== 1'b0) begin errors++; $display("FAIL err%0d_c: got %h ovf=%b want 0 0", i, c_flat, ovf); end
      end
   endtask

   task automatic test_ignore_start();
      logic [FW-1:0] a, b, ce;
      logic oe, ee, bf;
      int le, lat, extra;
      a = rand_mat(); b = rand_mat();
      expect_push(3'd3, 2, a, b, '0);
      issue(3'd3, 2, a, b, '0);
      repeat (2) @(negedge clock);
      opcode = 3'd1; matrix_size = 3'd1; a_flat = rand_mat(); start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done(lat, bf);
      lat = lat + 3;
      pop_exp(ce, oe, ee, le);
      checks++; if (lat !== 9) begin errors++; $display("FAIL ign_latency: got %0d want 9", lat); end
      checks++; if (c_flat !== ce || err !== 1'b0 || ovf !== oe) begin errors++; $display("FAIL ign_c: got %h want %h", c_flat, ce); end
      extra = 0;
      repeat (20) begin @(negedge clock); if (done) extra++; end
      checks++; if (extra !== 0) begin errors++; $display("FAIL ign_extra_done: got %0d want 0", extra); end
   endtask

   task automatic test_reset_abort();
      logic [FW-1:0] a, b, ce;
      logic oe, ee, bf;
      int le, lat, extra;
      a = rand_mat(); b = rand_mat();
      issue(3'd1, 3, a, b, '0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++; if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL abort_state: got busy=%b done=%b st=%0d want 0 0 0", busy, done, state_dbg); end
      checks++; if (c_flat !== '0 || ovf !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL abort_c: got %h want 0", c_flat); end
      reset = 1'b0;
      extra = 0;
      repeat (15) begin @(negedge clock); if (done) extra++; end
      checks++; if (extra !== 0) begin errors++; $display("FAIL abort_done: got %0d want 0", extra); end
      expect_push(3'd2, 3, a, b, '0);
      issue(3'd2, 3, a, b, '0);
      wait_done(lat, bf);
      pop_exp(ce, oe, ee, le);
      checks++; if (lat !== 10) begin errors++; $display("FAIL fresh_latency: got %0d want 10", lat); end
      checks++; if (c_flat !== ce || ovf !== oe) begin errors++; $display("FAIL fresh_c: got %h ovf=%b want %h %b", c_flat, ovf, ce, oe); end
   endtask

   task automatic test_back_to_back();
      logic [FW-1:0] a, b, ce;
      logic [DW-1:0] s;
      logic [2:0] op;
      logic oe, ee, bf;
      int n, le, lat;
      for (int i = 0; i < 8; i++) begin
         op = 3'($urandom_range(1, 6));
         n = $urandom_range(1, MN);
         a = rand_mat(); b = rand_mat(); s = 8'($urandom_range(0, 255));
         expect_push(op, n, a, b, s);
         issue(op, n, a, b, s);
         wait_done(lat, bf);
         pop_exp(ce, oe, ee, le);
         checks++; if (lat !== le) begin errors++; $display("FAIL b2b%0d_latency: op=%0d n=%0d got %0d want %0d", i, op, n, lat, le); end
         checks++; if (c_flat !== ce) begin errors++; $display("FAIL b2b%0d_c: op=%0d n=%0d got %h want %h", i, op, n, c_flat, ce); end
         checks++; if (ovf !== oe || err !== ee) begin errors++; $display("FAIL b2b%0d_flags: got ovf=%b err=%b want %b %b", i, ovf, err, oe, ee); end
      end
   endtask

   initial begin
      start = 1'b0; opcode = '0; matrix_size = '0;
      a_flat = '0; b_flat = '0; scalar = '0;
      test_reset();
      test_sum();
      test_multiply();
      test_overflow();
      test_transpose();
      test_error();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
